// File: rtl/data_pipe_pkg.sv
// Shared types and helpers for the data pipe blocks.
// Provides the default data width, the beat record and pointer sizing.
package data_pipe_pkg;

    localparam int DATA_WIDTH = 8;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    // One extra bit beyond the index so full and empty stay distinct.
    function automatic int clog2_ptr(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Beat storage for the frame FIFO: DEPTH x WIDTH registers, not reset.
// Ports: clk, wr_en/wr_addr/wr_data (sync write), rd_addr/rd_data (comb read).
module fifo_regfile #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_frame_fifo.sv
// First-word-fall-through AXI-Stream FIFO with beat and frame occupancy.
// Ports: clk, reset (async, active low), s_axis_* in, m_axis_* out,
// level (beats stored) and frames_held (stored beats carrying tlast).
module axis_frame_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] frames_held
);

    import data_pipe_pkg::clog2_ptr;

    localparam int PTR_W = clog2_ptr(DEPTH);
    localparam int AW    = PTR_W - 1;
    localparam logic [PTR_W-1:0] CAP = PTR_W'(DEPTH);

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    level_nxt;
    logic [PTR_W-1:0]    frames_nxt;
    logic                wr_en;
    logic                rd_en;
    logic                last_in;
    logic                last_out;
    logic [DATA_WIDTH:0] rd_word;

    assign wr_en         = s_axis_tvalid & s_axis_tready;
    assign m_axis_tvalid = (level != '0);
    assign rd_en         = m_axis_tvalid & m_axis_tready;
    assign last_in       = wr_en & s_axis_tlast;
    assign last_out      = rd_en & m_axis_tlast;

    always_comb begin
        level_nxt = level;
        case ({wr_en, rd_en})
            2'b10:   level_nxt = level + PTR_W'(1);
            2'b01:   level_nxt = level - PTR_W'(1);
            default: level_nxt = level;
        endcase
    end

    always_comb begin
        frames_nxt = frames_held;
        case ({last_in, last_out})
            2'b10:   frames_nxt = frames_held + PTR_W'(1);
            2'b01:   frames_nxt = frames_held - PTR_W'(1);
            default: frames_nxt = frames_held;
        endcase
    end

    // tready comes from next-state level, so a full FIFO refuses the
    // write even when a read frees a slot in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            frames_held   <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level         <= level_nxt;
            frames_held   <= frames_nxt;
            s_axis_tready <= (level_nxt < CAP);
        end
    end

    fifo_regfile #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    assign {m_axis_tlast, m_axis_tdata} = rd_word;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Self-checking bench for axis_frame_fifo.
// Directed vector table plus model-checked multi-cycle sequences.
module tb_axis_frame_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [4:0]    level;
    logic [4:0]    frames_held;

    always #5 clk = ~clk;

    axis_frame_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .level         (level),
        .frames_held   (frames_held)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          sl;
        logic          mr;
        logic          mv;
        logic [DW-1:0] md;
        logic          ml;
        int            lvl;
        int            fr;
        logic          sr;
    } vec_t;

    function automatic vec_t mk(
        input logic sv, input logic [DW-1:0] sd, input logic sl,
        input logic mr, input logic mv, input logic [DW-1:0] md,
        input logic ml, input int lvl, input int fr, input logic sr);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.mv = mv; v.md = md; v.ml = ml;
        v.lvl = lvl; v.fr = fr; v.sr = sr;
        return v;
    endfunction

    // Reference model: queue of {last, data}, frame count, registered ready.
    logic [DW:0] mq [$];
    int          m_fr;
    logic        m_rdy;

    task automatic step(input logic sv, input logic [DW-1:0] sd,
                        input logic sl, input logic mr,
                        output logic acc);
        logic        wr;
        logic        rd;
        logic [DW:0] head;
        s_axis_tvalid = sv;
        s_axis_tdata  = sd;
        s_axis_tlast  = sl;
        m_axis_tready = mr;
        @(negedge clk);
        wr = sv && m_rdy;
        rd = mr && (mq.size() != 0);
        if (mq.size() != 0) begin
            head = mq[0];
            chk("head data", int'(m_axis_tdata), int'(head[DW-1:0]));
            chk("head last", int'(m_axis_tlast), int'(head[DW]));
        end
        @(posedge clk);
        #1;
        if (rd) begin
            head = mq.pop_front();
            if (head[DW]) m_fr--;
        end
        if (wr) begin
            mq.push_back({sl, sd});
            if (sl) m_fr++;
        end
        m_rdy = (mq.size() < DEPTH);
        chk("level", int'(level), mq.size());
        chk("frames", int'(frames_held), m_fr);
        chk("m valid", int'(m_axis_tvalid), int'(mq.size() != 0));
        chk("s ready", int'(s_axis_tready), int'(m_rdy));
        acc = wr;
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 64 && mq.size() != 0; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        end
        chk("drained level", int'(level), 0);
    endtask

    vec_t tbl [10];

    initial begin
        logic acc;
        logic mr_r;
        int   sent;

        tbl[0] = mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 1);
        tbl[1] = mk(1, 8'h01, 0, 1, 1, 8'h01, 0, 1, 0, 1);
        tbl[2] = mk(1, 8'h02, 0, 1, 1, 8'h02, 0, 1, 0, 1);
        tbl[3] = mk(1, 8'h03, 0, 1, 1, 8'h03, 0, 1, 0, 1);
        tbl[4] = mk(1, 8'h04, 0, 1, 1, 8'h04, 0, 1, 0, 1);
        tbl[5] = mk(1, 8'h05, 1, 1, 1, 8'h05, 1, 1, 1, 1);
        tbl[6] = mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 1);
        tbl[7] = mk(1, 8'h11, 0, 0, 1, 8'h11, 0, 1, 0, 1);
        tbl[8] = mk(1, 8'hAA, 0, 1, 1, 8'hAA, 0, 1, 0, 1);
        tbl[9] = mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 1);

        reset         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst s ready", int'(s_axis_tready), 0);
        chk("rst m valid", int'(m_axis_tvalid), 0);
        chk("rst level", int'(level), 0);
        chk("rst frames", int'(frames_held), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            s_axis_tvalid = tbl[i].sv;
            s_axis_tdata  = tbl[i].sd;
            s_axis_tlast  = tbl[i].sl;
            m_axis_tready = tbl[i].mr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d mv", i), int'(m_axis_tvalid), int'(tbl[i].mv));
            chk($sformatf("vec%0d level", i), int'(level), tbl[i].lvl);
            chk($sformatf("vec%0d frames", i), int'(frames_held), tbl[i].fr);
            chk($sformatf("vec%0d sready", i), int'(s_axis_tready), int'(tbl[i].sr));
            if (tbl[i].mv) begin
                chk($sformatf("vec%0d data", i), int'(m_axis_tdata), int'(tbl[i].md));
                chk($sformatf("vec%0d last", i), int'(m_axis_tlast), int'(tbl[i].ml));
            end
        end

        mq.delete();
        m_fr  = 0;
        m_rdy = 1'b1;

        // Fill to capacity with the sink stalled.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), (i == 7) || (i == 15), 1'b0, acc);
        end
        chk("full level", int'(level), 16);
        chk("full frames", int'(frames_held), 2);
        chk("full sready", int'(s_axis_tready), 0);
        step(1'b1, 8'h10, 1'b0, 1'b0, acc);
        step(1'b1, 8'h10, 1'b0, 1'b0, acc);
        chk("17th refused", int'(level), 16);

        // Read and write offered together at full: only the read happens.
        step(1'b1, 8'h10, 1'b0, 1'b1, acc);
        chk("full rdwr level", int'(level), 15);
        chk("full rdwr sready", int'(s_axis_tready), 1);
        chk("full rdwr head", int'(m_axis_tdata), 8'h01);
        step(1'b1, 8'h10, 1'b0, 1'b1, acc);
        drain();

        // Streaming with random sink stalls, pointers wrap.
        sent = 0;
        for (int c = 0; c < 600 && sent < 40; c++) begin
            mr_r = 1'($urandom_range(0, 1));
            step(1'b1, 8'(32'h20 + sent), (sent % 8) == 7, mr_r, acc);
            if (acc) sent++;
        end
        chk("stream sent", sent, 40);
        drain();

        // Asynchronous reset in the middle of a partly stored frame.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(32'h40 + i), i == 2, 1'b0, acc);
        end
        chk("pre-rst level", int'(level), 6);
        #2;
        reset = 1'b0;
        #1;
        chk("async m valid", int'(m_axis_tvalid), 0);
        chk("async level", int'(level), 0);
        chk("async frames", int'(frames_held), 0);
        chk("async sready", int'(s_axis_tready), 0);
        mq.delete();
        m_fr  = 0;
        m_rdy = 1'b0;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        step(1'b1, 8'h50, 1'b0, 1'b1, acc);
        chk("post-rst head", int'(m_axis_tdata), 8'h50);
        step(1'b1, 8'h51, 1'b1, 1'b1, acc);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_frame_fifo.md
# axis_frame_fifo

Elastic AXI-Stream buffer placed directly downstream of `data_packer`, absorbing its `m_axis_*` output so bursty sink back-pressure does not stall packing. Stores data beats with their `tlast` marker in a first-word-fall-through FIFO. Reports occupancy in beats and in complete frames for flow control and debug.

## Interface
- `DATA_WIDTH`, 8, width of `tdata`.
- `DEPTH`, 16, FIFO capacity in beats; power of two, ≥ 2.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset; asserted (0) clears all state immediately.
- `s_axis_tdata` input `DATA_WIDTH`: write data from `data_packer`.
- `s_axis_tvalid` input 1: write beat valid.
- `s_axis_tready` output 1: FIFO can accept a beat.
- `s_axis_tlast` input 1: beat ends a frame.
- `m_axis_tdata` output `DATA_WIDTH`: head-of-FIFO data.
- `m_axis_tvalid` output 1: FIFO not empty.
- `m_axis_tready` input 1: sink accepts head beat.
- `m_axis_tlast` output 1: `tlast` stored with the head beat.
- `level` output `$clog2(DEPTH)+1`: beats currently stored, 0..DEPTH.
- `frames_held` output `$clog2(DEPTH)+1`: stored beats with `tlast`=1.

## Operation
- Write occurs when `s_axis_tvalid && s_axis_tready`; `{tlast, tdata}` is stored at `wr_ptr`, and `wr_ptr` increments.
- Read occurs when `m_axis_tvalid && m_axis_tready`; `rd_ptr` increments.
- Pointers are `$clog2(DEPTH)+1` bits wide and wrap naturally. Empty: pointers equal. Full: index bits equal and MSBs differ.
- `level` = `wr_ptr - rd_ptr` (modulo arithmetic). It is held in a register and updated: +1 on write only, −1 on read only, unchanged on both or neither.
- `frames_held` is a register: +1 on write with `s_axis_tlast`, −1 on read with `m_axis_tlast`, unchanged when both occur.
- `s_axis_tready` is registered; it is 1 when next-state `level` < DEPTH.
- When full, there is no write in the same cycle as a read; the slot freed by the read is usable from the next cycle.
- `m_axis_tvalid` = (`level` != 0).
- `m_axis_tdata`/`m_axis_tlast` are read combinationally from storage at `rd_ptr`.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata`/`m_axis_tlast` are held stable.
- Storage contents are not reset; only pointers, counters and `s_axis_tready` are.
- Reset asserted mid-frame discards all stored beats, including partial frames. No frame repair is performed.

## Timing
- Reset values:
  - `s_axis_tready`=0, `m_axis_tvalid`=0, `level`=0, `frames_held`=0.
  - `m_axis_tdata`/`m_axis_tlast` are don't-care while `m_axis_tvalid`=0.
- After `reset` deasserts, `s_axis_tready` rises at the first rising edge.
- Latency: a beat written at edge N appears at the output with `m_axis_tvalid`=1 after edge N. It can be read at edge N+1.
- Throughput: one write and one read per cycle sustained when neither empty nor full.
- Full boundary: the write that makes `level`=DEPTH drops `s_axis_tready` in the following cycle, with no extra accepted beat.
- Empty boundary: a simultaneous write and read at `level`=1 keeps `m_axis_tvalid`=1 with the new beat.
- A write at `level`=0 cannot be read in the same cycle (no bypass).

## Structure
- Shared package `data_pipe_pkg`:
  - `DATA_WIDTH` default.
  - typedef `beat_t` (`{logic last; logic [DATA_WIDTH-1:0] data;}`).
  - function `clog2_ptr(depth)` returning pointer width.
- Sub-module `fifo_regfile`: DEPTH × `beat_t` register array with one synchronous write port and one combinational read port.
- The top level holds pointers, counters and handshake logic.

## Test plan
- Reset, idle, then send 5 beats 0x01..0x05 with last on 0x05 and `m_axis_tready`=1 → `m_axis_tdata` shows 0x01..0x05 one cycle after each write; `m_axis_tlast`=1 only with 0x05; `level` peaks at 1; `frames_held` returns to 0.
- `m_axis_tready`=0, then push DEPTH=16 beats 0x00..0x0F with tlast on 0x07 and 0x0F → `level`=16, `frames_held`=2, `s_axis_tready`=0, and a 17th beat 0x10 is not accepted; after releasing `m_axis_tready`, output is 0x00..0x0F then 0x10.
- At full, assert read and `s_axis_tvalid` in the same cycle → exactly one beat leaves, none enters that cycle; `level`=15, and `s_axis_tready`=1 the next cycle.
- Continuous streaming of 40 beats with random `m_axis_tready` (~50%) and pointers wrapping twice → output order and data match input exactly; `level` never exceeds 16 nor underflows.
- Load 6 beats including one tlast, then assert `reset`=0 asynchronously mid-cycle → `m_axis_tvalid`, `level`, `frames_held` = 0 immediately; after release, the first output beat is the first beat written post-reset.
- `level`=1 with simultaneous write of 0xAA and read → `m_axis_tvalid` stays 1, next head = 0xAA, `level` stays 1.
